// File: rtl/cu_reg_multicycle.sv
// cu_reg_multicycle: multi-cycle control unit for LEGv8 R-format instructions.
// Runs each instruction through FETCH -> DECODE -> EXEC. Shifts take one SHIFT
// cycle per bit position, and MUL waits in MUL_WAIT for an external multiplier.
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   ir                    instruction register (valid the cycle after IR_load)
//   mem_ready             instruction read complete
//   mul_done              multiplier result valid (1-cycle pulse)
//   FS, C0                ALU function select / carry-in
//   SA, SB, DA, w_reg     register-file read A/B, write address, write enable
//   status_load           load NZCV flags
//   mem_cs, IR_load       instruction memory select, IR latch enable
//   PC_FS                 PC function (01 = PC+4)
//   mul_start, mul_sel    multiplier start pulse, write-back source select
//   illegal, retire       unsupported opcode / instruction completed pulses
//   state, NS             current / next state
module cu_reg_multicycle #(
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = 6,
  parameter int ENABLE_MUL = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           ir,
  input  logic                  mem_ready,
  input  logic                  mul_done,
  output logic [4:0]            FS,
  output logic [REG_ADDR_W-1:0] SA,
  output logic [REG_ADDR_W-1:0] SB,
  output logic [REG_ADDR_W-1:0] DA,
  output logic                  w_reg,
  output logic                  C0,
  output logic                  status_load,
  output logic [1:0]            mem_cs,
  output logic                  IR_load,
  output logic [1:0]            PC_FS,
  output logic                  mul_start,
  output logic                  mul_sel,
  output logic                  illegal,
  output logic                  retire,
  output logic [2:0]            state,
  output logic [2:0]            NS
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_SHIFT = 3'd3, S_MUL_WAIT = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ANDS, OP_ORR, OP_EOR,
    OP_LSL, OP_LSR, OP_MUL, OP_MOV, OP_BAD
  } op_t;

  localparam logic [REG_ADDR_W-1:0] XZR = {REG_ADDR_W{1'b1}};

  state_t                state_q, ns;
  op_t                   op_q, dec_op;
  logic [REG_ADDR_W-1:0] rd_q, rn_q, rm_q;
  logic [SHAMT_W-1:0]    cnt_q, shamt;
  logic                  first_q;  // first cycle of SHIFT / MUL_WAIT

  assign shamt = SHAMT_W'(ir[15:10]);

  // Opcode decode; a zero-distance shift degenerates into a move through EXEC.
  always_comb begin
    dec_op = OP_BAD;
    case (ir[31:21])
      11'b10001011000: dec_op = OP_ADD;
      11'b10101011000: dec_op = OP_ADDS;
      11'b11001011000: dec_op = OP_SUB;
      11'b11101011000: dec_op = OP_SUBS;
      11'b10001010000: dec_op = OP_AND;
      11'b11101010000: dec_op = OP_ANDS;
      11'b10101010000: dec_op = OP_ORR;
      11'b11001010000: dec_op = OP_EOR;
      11'b11010011011: dec_op = (shamt == '0) ? OP_MOV : OP_LSL;
      11'b11010011010: dec_op = (shamt == '0) ? OP_MOV : OP_LSR;
      11'b10011011000: dec_op = (ENABLE_MUL != 0) ? OP_MUL : OP_BAD;
      default:         dec_op = OP_BAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= ns;
      case (state_q)
        S_DECODE: begin
          op_q    <= dec_op;
          rd_q    <= REG_ADDR_W'(ir[4:0]);
          rn_q    <= REG_ADDR_W'(ir[9:5]);
          rm_q    <= REG_ADDR_W'(ir[20:16]);
          cnt_q   <= shamt;
          first_q <= 1'b1;
        end
        S_SHIFT: begin
          cnt_q   <= cnt_q - 1'b1;
          first_q <= 1'b0;
        end
        S_MUL_WAIT: first_q <= 1'b0;
        default: ;
      endcase
    end
  end

  logic [4:0]            fs_c;
  logic [REG_ADDR_W-1:0] sa_c, sb_c, da_c;
  logic                  w_c, c0_c, sl_c, irl_c, ms_c, msel_c, ill_c, ret_c;
  logic [1:0]            cs_c, pc_c;

  always_comb begin
    ns     = S_FETCH;
    fs_c   = '0;
    sa_c   = '0;
    sb_c   = '0;
    da_c   = '0;
    w_c    = 1'b0;
    c0_c   = 1'b0;
    sl_c   = 1'b0;
    cs_c   = 2'b00;
    irl_c  = 1'b0;
    pc_c   = 2'b00;
    ms_c   = 1'b0;
    msel_c = 1'b0;
    ill_c  = 1'b0;
    ret_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        cs_c = 2'b01;
        if (mem_ready) begin
          irl_c = 1'b1;
          pc_c  = 2'b01;
          ns    = S_DECODE;
        end else begin
          ns = S_FETCH;
        end
      end
      S_DECODE: begin
        case (dec_op)
          OP_BAD:         ill_c = 1'b1;
          OP_LSL, OP_LSR: ns = S_SHIFT;
          OP_MUL:         ns = S_MUL_WAIT;
          default:        ns = S_EXEC;
        endcase
      end
      S_EXEC: begin
        sa_c  = rn_q;
        sb_c  = (op_q == OP_MOV) ? XZR : rm_q;
        da_c  = rd_q;
        w_c   = 1'b1;
        ret_c = 1'b1;
        sl_c  = (op_q == OP_ADDS) || (op_q == OP_SUBS) || (op_q == OP_ANDS);
        case (op_q)
          OP_SUB, OP_SUBS: begin fs_c = 5'b01001; c0_c = 1'b1; end
          OP_AND, OP_ANDS: fs_c = 5'b00000;
          OP_ORR:          fs_c = 5'b00100;
          OP_EOR:          fs_c = 5'b01100;
          default:         fs_c = 5'b01000;
        endcase
      end
      S_SHIFT: begin
        // The first step reads the source; later steps shift the partial result in Rd.
        sa_c = first_q ? rn_q : rd_q;
        da_c = rd_q;
        w_c  = 1'b1;
        fs_c = (op_q == OP_LSR) ? 5'b10100 : 5'b10000;
        if (cnt_q <= SHAMT_W'(1)) begin
          ret_c = 1'b1;
          ns    = S_FETCH;
        end else begin
          ns = S_SHIFT;
        end
      end
      S_MUL_WAIT: begin
        sa_c = rn_q;
        sb_c = rm_q;
        ms_c = first_q;
        if (mul_done) begin
          w_c    = 1'b1;
          msel_c = 1'b1;
          da_c   = rd_q;
          ret_c  = 1'b1;
          ns     = S_FETCH;
        end else begin
          ns = S_MUL_WAIT;
        end
      end
      default: ns = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so the datapath sees no stray enables.
  assign FS          = reset_n ? fs_c   : '0;
  assign SA          = reset_n ? sa_c   : '0;
  assign SB          = reset_n ? sb_c   : '0;
  assign DA          = reset_n ? da_c   : '0;
  assign w_reg       = reset_n & w_c;
  assign C0          = reset_n & c0_c;
  assign status_load = reset_n & sl_c;
  assign mem_cs      = reset_n ? cs_c   : 2'b00;
  assign IR_load     = reset_n & irl_c;
  assign PC_FS       = reset_n ? pc_c   : 2'b00;
  assign mul_start   = reset_n & ms_c;
  assign mul_sel     = reset_n & msel_c;
  assign illegal     = reset_n & ill_c;
  assign retire      = reset_n & ret_c;
  assign state       = state_q;
  assign NS          = ns;
endmodule
